// File: rtl/ws2812_frame_tx_if.sv
// Pixel-index / colour handshake between the colour-mapping logic (master) and the WS2812 transmitter (slave).
// Also carries the frame request and the busy/frame_done status.
interface ws2812_frame_tx_if #(
   parameter int IDX_W = 7
);
   logic             start;
   logic [23:0]      color_in;
   logic [IDX_W-1:0] pixel_idx;
   logic             busy;
   logic             frame_done;

   modport master (
      output start,
      output color_in,
      input  pixel_idx,
      input  busy,
      input  frame_done
   );

   modport slave (
      input  start,
      input  color_in,
      output pixel_idx,
      output busy,
      output frame_done
   );
endinterface

// File: rtl/ws2812_frame_tx.sv
// WS2812 frame transmitter: walks pixel_idx across the frame, shifts each 24-bit colour out MSB-first
// as one-wire pulses with no inter-pixel gap, then holds the line low for the latch interval.
module ws2812_frame_tx #(
   parameter int NUM_PIXELS = 128,
   parameter int BIT_CYC    = 63,
   parameter int T0H_CYC    = 20,
   parameter int T1H_CYC    = 40,
   parameter int RESET_CYC  = 2500
) (
   input  logic             clk,
   input  logic             rst_n,
   ws2812_frame_tx_if.slave pix_if,
   output logic             dout
);
   localparam int IDX_W   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
   localparam int CNT_MAX = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX);

   localparam logic [IDX_W-1:0] LAST_PIX   = IDX_W'(NUM_PIXELS - 1);
   localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYC - 1);
   localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(RESET_CYC - 1);
   localparam logic [CNT_W-1:0] T0H        = CNT_W'(T0H_CYC);
   localparam logic [CNT_W-1:0] T1H        = CNT_W'(T1H_CYC);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      SEND,
      LATCH
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       bit_q, bit_d;
   logic [23:0]      shift_q, shift_d;
   logic [IDX_W-1:0] pix_q, pix_d;
   logic             fin_q, fin_d;
   logic             dout_q, dout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             bit_end;
   logic [CNT_W-1:0] high_len;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      pix_d    = pix_q;
      fin_d    = fin_q;
      bit_end  = (cnt_q == BIT_LAST);

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            pix_d = '0;
            fin_d = 1'b0;
            if (pix_if.start) begin
               state_d = FETCH;
            end
         end

         FETCH: begin
            state_d = LOAD;
         end

         LOAD: begin
            shift_d = pix_if.color_in;
            bit_d   = 5'd23;
            cnt_d   = '0;
            state_d = SEND;
         end

         SEND: begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
            // Step the index at the start of the last bit so the next colour settles before it is sampled;
            // fin remembers that the pixel being sent is the final one, since pix_q alone cannot tell.
            if (bit_q == 5'd0 && cnt_q == '0) begin
               if (pix_q == LAST_PIX) begin
                  fin_d = 1'b1;
               end else begin
                  pix_d = pix_q + 1'b1;
               end
            end
            if (bit_end) begin
               if (bit_q != 5'd0) begin
                  bit_d   = bit_q - 1'b1;
                  shift_d = {shift_q[22:0], 1'b0};
               end else if (fin_q) begin
                  state_d = LATCH;
               end else begin
                  shift_d = pix_if.color_in;
                  bit_d   = 5'd23;
               end
            end
         end

         LATCH: begin
            if (cnt_q == LATCH_LAST) begin
               cnt_d   = '0;
               pix_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered from the next-state values so they line up with the counter they describe.
      high_len = shift_d[23] ? T1H : T0H;
      dout_d   = (state_d == SEND) && (cnt_d < high_len);
      busy_d   = (state_d != IDLE);
      done_d   = (state_d == LATCH) && (cnt_d == LATCH_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         pix_q   <= '0;
         fin_q   <= 1'b0;
         dout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         pix_q   <= pix_d;
         fin_q   <= fin_d;
         dout_q  <= dout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign pix_if.pixel_idx  = pix_q;
   assign pix_if.busy       = busy_q;
   assign pix_if.frame_done = done_q;
   assign dout              = dout_q;
endmodule

// File: tb/tb_ws2812_frame_tx.sv
// Bench for ws2812_frame_tx: colour lookup by pixel_idx, cycle-by-cycle comparison against an
// arithmetic model of the frame waveform, plus per-pixel colour decode from measured pulse widths.
module tb_ws2812_frame_tx;
   localparam int N         = 4;
   localparam int B         = 10;
   localparam int T0        = 3;
   localparam int T1        = 6;
   localparam int R         = 20;
   localparam int IDXW      = $clog2(N);
   localparam int PIX_CYC   = 24 * B;
   localparam int SEND_CYC  = N * PIX_CYC;
   localparam int FRAME_LEN = 2 + SEND_CYC + R;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        dout;
   logic [23:0] colors [N];
   logic [23:0] snap   [N];
   int          n_tests = 0;
   int          n_fail  = 0;

   ws2812_frame_tx_if #(.IDX_W(IDXW)) pif ();

   ws2812_frame_tx #(
      .NUM_PIXELS(N),
      .BIT_CYC   (B),
      .T0H_CYC   (T0),
      .T1H_CYC   (T1),
      .RESET_CYC (R)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pix_if(pif.slave),
      .dout  (dout)
   );

   always #5 clk = ~clk;

   assign pif.color_in = colors[pif.pixel_idx];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Cycle c counts from 1 = first cycle after the edge that captured start.
   function automatic logic model_dout(input int c);
      int s, p, i, ph;
      if (c < 3 || c > 2 + SEND_CYC) return 1'b0;
      s  = c - 3;
      p  = s / PIX_CYC;
      i  = 23 - (s % PIX_CYC) / B;
      ph = s % B;
      return (ph < (snap[p][i] ? T1 : T0));
   endfunction

   function automatic int model_idx(input int c);
      int s, p, i, ph;
      if (c <= 2) return 0;
      if (c > 2 + SEND_CYC) return (c > FRAME_LEN) ? 0 : N - 1;
      s  = c - 3;
      p  = s / PIX_CYC;
      i  = 23 - (s % PIX_CYC) / B;
      ph = s % B;
      if (i == 0 && ph >= 1 && p < N - 1) return p + 1;
      return p;
   endfunction

   // Caller raises start just after an edge with the DUT idle; the task returns in the cycle after frame_done.
   task automatic run_frame(input bit hold_start, input bit glitch, input int inj_pix);
      int          hi [N][24];
      int          dout_err = 0;
      int          idx_err  = 0;
      int          busy_err = 0;
      int          done_cnt = 0;
      int          done_at  = -1;
      int          bad_w    = 0;
      int          s;
      logic [23:0] dec;
      for (int k = 0; k < N; k++) begin
         snap[k] = colors[k];
         for (int b = 0; b < 24; b++) hi[k][b] = 0;
      end
      @(posedge clk);
      #1;
      if (!hold_start) pif.start = 1'b0;
      for (int c = 1; c <= FRAME_LEN + 1; c++) begin
         if (dout !== model_dout(c)) dout_err++;
         if (32'(pif.pixel_idx) !== model_idx(c)) idx_err++;
         if (pif.busy !== (c <= FRAME_LEN)) busy_err++;
         if (pif.frame_done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = c;
         end
         if (c >= 3 && c <= 2 + SEND_CYC && dout === 1'b1) begin
            s = c - 3;
            hi[s / PIX_CYC][23 - (s % PIX_CYC) / B]++;
         end
         if (c == FRAME_LEN + 1) check_eq("busy_after_done", 32'(pif.busy), 32'(0));
         if (glitch && !hold_start) begin
            if (c >= 5 && c <= 900) pif.start = 1'($urandom_range(0, 1));
            else pif.start = 1'b0;
         end
         if (inj_pix >= 0 && c == 3 + inj_pix * PIX_CYC + 3 * B) colors[inj_pix] = ~snap[inj_pix];
         if (c <= FRAME_LEN) begin
            @(posedge clk);
            #1;
         end
      end
      check_eq("dout_wave_errs", dout_err, 0);
      check_eq("pixel_idx_errs", idx_err, 0);
      check_eq("busy_errs", busy_err, 0);
      check_eq("frame_done_cnt", done_cnt, 1);
      check_eq("frame_done_at", done_at, FRAME_LEN);
      for (int k = 0; k < N; k++) begin
         dec = '0;
         for (int b = 0; b < 24; b++) begin
            if (hi[k][b] == T1) dec[b] = 1'b1;
            else if (hi[k][b] != T0) bad_w++;
         end
         check_eq("pixel_color", 32'(dec), 32'(snap[k]));
      end
      check_eq("pulse_width_bad", bad_w, 0);
   endtask

   task automatic rand_colors();
      for (int k = 0; k < N; k++) colors[k] = 24'($urandom);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rst_cyc;
      int done_seen;
      pif.start = 1'b0;
      for (int k = 0; k < N; k++) colors[k] = '0;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_dout", 32'(dout), 32'(0));
      check_eq("rst_busy", 32'(pif.busy), 32'(0));
      check_eq("rst_done", 32'(pif.frame_done), 32'(0));
      check_eq("rst_idx", 32'(pif.pixel_idx), 32'(0));
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("idle_busy", 32'(pif.busy), 32'(0));

      // Directed colour patterns
      colors[0] = 24'h800000;
      colors[1] = 24'h000001;
      colors[2] = 24'hAAAAAA;
      colors[3] = 24'h555555;
      pif.start = 1'b1;
      run_frame(1'b0, 1'b0, -1);
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) colors[k] = 24'h000000;
      pif.start = 1'b1;
      run_frame(1'b0, 1'b0, -1);
      for (int k = 0; k < N; k++) colors[k] = 24'hFFFFFF;
      pif.start = 1'b1;
      run_frame(1'b0, 1'b0, -1);

      // Colour changes after the sample point must not reach the line
      rand_colors();
      pif.start = 1'b1;
      run_frame(1'b0, 1'b0, 1);
      pif.start = 1'b1;
      run_frame(1'b0, 1'b0, 3);

      // Continuous refresh, then mid-frame start pulses
      rand_colors();
      pif.start = 1'b1;
      run_frame(1'b1, 1'b0, -1);
      run_frame(1'b1, 1'b0, 0);
      run_frame(1'b1, 1'b0, -1);
      pif.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("stop_busy", 32'(pif.busy), 32'(0));
      rand_colors();
      pif.start = 1'b1;
      run_frame(1'b0, 1'b1, -1);

      // Reset in the middle of pixel 2
      repeat (2) @(posedge clk);
      #1;
      rand_colors();
      for (int k = 0; k < N; k++) snap[k] = colors[k];
      rst_cyc = 3 + 2 * PIX_CYC + 51;
      pif.start = 1'b1;
      @(posedge clk);
      #1;
      pif.start = 1'b0;
      repeat (rst_cyc - 1) @(posedge clk);
      #1;
      check_eq("pre_rst_idx", 32'(pif.pixel_idx), model_idx(rst_cyc));
      check_eq("pre_rst_dout", 32'(dout), 32'(model_dout(rst_cyc)));
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("midrst_dout", 32'(dout), 32'(0));
      check_eq("midrst_busy", 32'(pif.busy), 32'(0));
      check_eq("midrst_idx", 32'(pif.pixel_idx), 32'(0));
      done_seen = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (c == 4) rst_n = 1'b1;
         if (pif.frame_done === 1'b1) done_seen++;
      end
      check_eq("midrst_no_done", done_seen, 0);
      check_eq("midrst_idle_busy", 32'(pif.busy), 32'(0));
      pif.start = 1'b1;
      run_frame(1'b0, 1'b0, -1);

      // Random frames with random idle gaps
      for (int f = 0; f < 3; f++) begin
         repeat ($urandom_range(1, 5)) @(posedge clk);
         #1;
         rand_colors();
         pif.start = 1'b1;
         run_frame(1'b0, 1'b0, -1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
